// File: rtl/ram_req_arb.sv
// Two-client arbiter in front of a dual-port RAM: client A owns RAM port A, client B owns port B.
// Same-address collisions are resolved by stalling one client for a cycle.

// Per-client RAM-side registers and read-return pipeline.
module ram_req_arb_port #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic [AW-1:0] ram_addr_wr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    localparam int PIPE_W = RD_LAT + 1;

    logic [AW-1:0]     ram_addr_d,    ram_addr_q;
    logic [AW-1:0]     ram_addr_wr_d, ram_addr_wr_q;
    logic [DW-1:0]     ram_data_in_d, ram_data_in_q;
    logic              ram_we_d,      ram_we_q;
    logic [PIPE_W-1:0] rd_pipe_d,     rd_pipe_q;
    logic [DW-1:0]     rdata_d,       rdata_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ram_addr_d    = ram_addr_q;
        ram_addr_wr_d = ram_addr_wr_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        rd_pipe_d     = (rd_pipe_q << 1) | PIPE_W'(acc && !we);
        rdata_d       = rdata_q;
        if (acc) begin
            if (we) begin
                ram_addr_wr_d = addr;
                ram_data_in_d = wdata;
                ram_we_d      = 1'b1;
            end else begin
                ram_addr_d = addr;
            end
        end
        if (rvalid) begin
            rdata_d = ram_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q    <= '0;
            ram_addr_wr_q <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            rd_pipe_q     <= '0;
            rdata_q       <= '0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_addr_wr_q <= ram_addr_wr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            rd_pipe_q     <= rd_pipe_d;
            rdata_q       <= rdata_d;
        end
    end

    // Return data passes straight through in the valid cycle and is held afterwards.
    assign rvalid      = rd_pipe_q[RD_LAT];
    assign rdata       = rvalid ? ram_data : rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_addr_wr = ram_addr_wr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_we      = ram_we_q;

endmodule

module ram_req_arb #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_addr_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [AW-1:0] ram_addr_wr_a,
    output logic [AW-1:0] ram_addr_wr_b,
    output logic [DW-1:0] ram_data_in_a,
    output logic [DW-1:0] ram_data_in_b,
    output logic          ram_we_a,
    output logic          ram_we_b,
    input  logic [DW-1:0] ram_data_a,
    input  logic [DW-1:0] ram_data_b,
    output logic [15:0]   conflict_cnt
);

    logic        ww_conflict, rw_conflict;
    logic        a_acc, b_acc;
    logic        prio_d, prio_q;
    logic [15:0] conflict_cnt_d, conflict_cnt_q;

    always_comb begin
        ww_conflict = a_valid && b_valid && (a_addr == b_addr) && a_we && b_we;
        rw_conflict = a_valid && b_valid && (a_addr == b_addr) && (a_we != b_we);
        a_ready     = !rst;
        b_ready     = !rst;
        if (ww_conflict) begin
            a_ready = !rst && !prio_q;
            b_ready = !rst && prio_q;
        end else if (rw_conflict) begin
            // The writer goes first so the stalled reader sees the new data.
            a_ready = !rst && a_we;
            b_ready = !rst && b_we;
        end
    end

    assign a_acc = a_valid && a_ready;
    assign b_acc = b_valid && b_ready;

    always_comb begin
        prio_d         = prio_q ^ ww_conflict;
        conflict_cnt_d = conflict_cnt_q;
        if ((ww_conflict || rw_conflict) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q         <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            prio_q         <= prio_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    ram_req_arb_port #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_port_a (
        .clk         (clk),
        .rst         (rst),
        .acc         (a_acc),
        .we          (a_we),
        .addr        (a_addr),
        .wdata       (a_wdata),
        .ram_data    (ram_data_a),
        .ram_addr    (ram_addr_a),
        .ram_addr_wr (ram_addr_wr_a),
        .ram_data_in (ram_data_in_a),
        .ram_we      (ram_we_a),
        .rvalid      (a_rvalid),
        .rdata       (a_rdata)
    );

    ram_req_arb_port #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_port_b (
        .clk         (clk),
        .rst         (rst),
        .acc         (b_acc),
        .we          (b_we),
        .addr        (b_addr),
        .wdata       (b_wdata),
        .ram_data    (ram_data_b),
        .ram_addr    (ram_addr_b),
        .ram_addr_wr (ram_addr_wr_b),
        .ram_data_in (ram_data_in_b),
        .ram_we      (ram_we_b),
        .rvalid      (b_rvalid),
        .rdata       (b_rdata)
    );

endmodule

// File: tb/tb_ram_req_arb.sv
// Directed bench for ram_req_arb with a synchronous dual-port RAM model (one-cycle read latency).
module tb_ram_req_arb;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic          clk, rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ram_addr_a, ram_addr_b, ram_addr_wr_a, ram_addr_wr_b;
    logic [DW-1:0] ram_data_in_a, ram_data_in_b, ram_data_a, ram_data_b;
    logic          ram_we_a, ram_we_b;
    logic [15:0]   conflict_cnt;

    ram_req_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_we          (a_we),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .a_rvalid      (a_rvalid),
        .a_rdata       (a_rdata),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_we          (b_we),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .b_rvalid      (b_rvalid),
        .b_rdata       (b_rdata),
        .ram_addr_a    (ram_addr_a),
        .ram_addr_b    (ram_addr_b),
        .ram_addr_wr_a (ram_addr_wr_a),
        .ram_addr_wr_b (ram_addr_wr_b),
        .ram_data_in_a (ram_data_in_a),
        .ram_data_in_b (ram_data_in_b),
        .ram_we_a      (ram_we_a),
        .ram_we_b      (ram_we_b),
        .ram_data_a    (ram_data_a),
        .ram_data_b    (ram_data_b),
        .conflict_cnt  (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: address registered at the edge, data out the following cycle.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_wr_a] <= ram_data_in_a;
        if (ram_we_b) mem[ram_addr_wr_b] <= ram_data_in_b;
        ram_data_a <= mem[ram_addr_a];
        ram_data_b <= mem[ram_addr_b];
    end

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
    endtask

    // Called one negedge after acceptance; lat counts clock edges since acceptance, inclusive.
    task automatic wait_a_rvalid(output int lat);
        lat = 1;
        while (!a_rvalid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
        #1 check({tag, "_rdy"}, a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check({tag, "_we"}, ram_we_a, 1);
        check({tag, "_waddr"}, ram_addr_wr_a, addr);
        check({tag, "_wdata"}, ram_data_in_a, data);
        @(negedge clk);
        check({tag, "_we_pulse"}, ram_we_a, 0);
    endtask

    task automatic a_read_check(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        int lat;
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = addr;
        #1 check({tag, "_rdy"}, a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check({tag, "_raddr"}, ram_addr_a, addr);
        wait_a_rvalid(lat);
        check({tag, "_lat"}, lat, 1 + RD_LAT);
        check({tag, "_rdata"}, a_rdata, exp);
        @(negedge clk);
        check({tag, "_rvalid_pulse"}, a_rvalid, 0);
        check({tag, "_rdata_hold"}, a_rdata, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, pulses, first, last, bad, a_acc_cnt;
        logic p;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        idle_inputs();
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

        #2;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_we_a", ram_we_a, 0);
        check("rst_we_b", ram_we_b, 0);
        check("rst_rvalid_a", a_rvalid, 0);
        check("rst_rdata_a", a_rdata, 0);
        check("rst_cnt", conflict_cnt, 0);

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("idle_a_ready", a_ready, 1);
        check("idle_b_ready", b_ready, 1);

        // Write then read on client A.
        a_write("wr_a", 8'd1, 32'hA5A5_A5A5);
        a_read_check("rd_a", 8'd1, 32'hA5A5_A5A5);

        // W-W on addr 1 with prio=0: A first, B the cycle after.
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 8'd1; a_wdata = 32'hA5A5_A5A5;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 8'd1; b_wdata = 32'h5A5A_5A5A;
        #1;
        check("ww_a_ready", a_ready, 1);
        check("ww_b_ready", b_ready, 0);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("ww_b_ready_next", b_ready, 1);
        check("ww_a_we", ram_we_a, 1);
        @(negedge clk);
        b_valid = 1'b0;
        check("ww_b_we", ram_we_b, 1);
        check("ww_b_wdata", ram_data_in_b, 32'h5A5A_5A5A);
        check("ww_cnt", conflict_cnt, 1);
        a_read_check("ww_rd", 8'd1, 32'h5A5A_5A5A);

        // R-W on addr 3: writer B goes first, reader A next cycle sees new data.
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'd3;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 8'd3; b_wdata = 32'h1234_5678;
        #1;
        check("rw_b_ready", b_ready, 1);
        check("rw_a_ready", a_ready, 0);
        @(negedge clk);
        b_valid = 1'b0;
        #1 check("rw_a_ready_next", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        wait_a_rvalid(lat);
        check("rw_lat", lat, 1 + RD_LAT);
        check("rw_rdata", a_rdata, 32'h1234_5678);
        check("rw_cnt", conflict_cnt, 2);

        // Non-conflicting patterns leave both clients ready.
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'd3;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 8'd3;
        #1;
        check("rr_a_ready", a_ready, 1);
        check("rr_b_ready", b_ready, 1);
        a_we = 1'b1; a_addr = 8'd9; b_we = 1'b1; b_addr = 8'd10;
        #1;
        check("ww_diff_a_ready", a_ready, 1);
        check("ww_diff_b_ready", b_ready, 1);
        idle_inputs();
        @(negedge clk);
        check("noconf_cnt", conflict_cnt, 2);

        // Fill addrs 0..7 through B, then stream reads through A.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_valid = 1'b1; b_we = 1'b1; b_addr = AW'(i); b_wdata = 32'hC0DE_0000 + DW'(i);
        end
        @(negedge clk);
        b_valid = 1'b0;
        pulses = 0; first = -1; last = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (a_rvalid) begin
                check($sformatf("tput_d%0d", pulses), a_rdata, 32'hC0DE_0000 + DW'(pulses));
                if (first < 0) first = c;
                last = c;
                pulses++;
            end
            if (c < 8) begin
                a_valid = 1'b1; a_we = 1'b0; a_addr = AW'(c);
            end else begin
                a_valid = 1'b0;
            end
        end
        check("tput_pulses", pulses, 8);
        check("tput_span", last - first, 7);

        // Sustained W-W: prio is 1 after the single earlier W-W, so B wins first.
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 8'd5; a_wdata = 32'h1111_1111;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 8'd5; b_wdata = 32'h2222_2222;
        p = 1'b1; bad = 0; a_acc_cnt = 0;
        for (int n = 0; n < 70000; n++) begin
            #1;
            if (a_ready !== !p || b_ready !== p) bad++;
            if (a_ready) a_acc_cnt++;
            @(negedge clk);
            p = !p;
        end
        idle_inputs();
        check("sat_alternate", bad, 0);
        check("sat_a_acc", a_acc_cnt, 35000);
        @(negedge clk);
        check("sat_cnt", conflict_cnt, 16'hFFFF);

        // Reset pulse while a read is in flight.
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'd2;
        @(negedge clk);
        a_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_a_ready", a_ready, 0);
        check("arst_b_ready", b_ready, 0);
        check("arst_addr_a", ram_addr_a, 0);
        check("arst_addr_wr_a", ram_addr_wr_a, 0);
        check("arst_addr_wr_b", ram_addr_wr_b, 0);
        check("arst_data_in_b", ram_data_in_b, 0);
        check("arst_cnt", conflict_cnt, 0);
        check("arst_rvalid_a", a_rvalid, 0);
        check("arst_rdata_a", a_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_rvalid) bad++;
        end
        check("arst_no_rvalid", bad, 0);

        a_read_check("post_rst", 8'd0, 32'hC0DE_0000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ram_req_arb.md
RAM_REQ_ARB -- requirements
Module: ram_req_arb

Interface
REQ-001 SHALL have parameter AW, default 8, address width (256 words).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in clk cycles from address valid at RAM to data valid at RAM output (range 0-3).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have client A ports: a_valid in 1; a_ready out 1; a_we in 1 (1=write, 0=read); a_addr in AW; a_wdata in DW; a_rvalid out 1; a_rdata out DW.
REQ-006 SHALL have client B ports b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata, with the same directions and widths as client A.
REQ-007 SHALL have RAM-side ports: ram_addr_a, ram_addr_b, ram_addr_wr_a, ram_addr_wr_b out AW; ram_data_in_a, ram_data_in_b out DW; ram_we_a, ram_we_b out 1; ram_data_a, ram_data_b in DW.
REQ-008 SHALL have conflict_cnt out 16, a saturating count of arbitration conflicts.

Function
REQ-009 Request accepted when x_valid && x_ready at a rising clk edge; x_ready is combinational from valids, we, addr and the prio register.
REQ-010 Client A maps to RAM port A and client B to RAM port B; accepted request drives RAM signals from registers, visible the cycle after acceptance.
REQ-011 Accepted write: ram_addr_wr_x=addr, ram_data_in_x=wdata, ram_we_x=1 for exactly one cycle; ram_we_x=0 otherwise.
REQ-012 Accepted read: ram_addr_x=addr held until the next accepted read on that port.
REQ-013 Read response: x_rvalid high one cycle, 1+RD_LAT cycles after acceptance; x_rdata = ram_data_x in that cycle; x_rdata holds its last value otherwise.
REQ-014 Conflict W-W: both valid, both we, equal addr -> only the prio client is ready; the other sees ready=0.
REQ-015 Conflict R-W: both valid, one write, one read, equal addr -> writer ready, reader ready=0, so the reader samples post-write data the following cycle; prio is not used.
REQ-016 Reads to equal addr from both clients, or any non-equal addresses -> both ready, no conflict.
REQ-017 prio: 1-bit register, 0 = A favoured; toggles on every W-W conflict cycle, giving round-robin fairness.
REQ-018 conflict_cnt increments by 1 on every W-W or R-W conflict cycle and saturates at 16'hFFFF.
REQ-019 Per-client read pipeline: shift register of depth 1+RD_LAT carrying the valid bit; back-to-back reads every cycle are supported at full throughput.
REQ-020 With no conflicts, a_ready=b_ready=1 every cycle, whether or not valid is asserted.

Reset
REQ-021 While rst=1: a_ready=b_ready=0, all ram_we_x=0, all ram addr/data outputs=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, prio=0, conflict_cnt=0.
REQ-022 rst assertion SHALL clear outputs immediately, without waiting for clk; in-flight reads are discarded and their rvalid never asserts.
REQ-023 First acceptance possible at the first rising edge after rst deasserts.

Verification
REQ-024 Reset: rst pulse mid-read, RD_LAT=1 -> a_rvalid stays 0, all outputs 0 asynchronously, conflict_cnt=0.
REQ-025 Write/read A: write addr 1 data A5A5A5A5, then read addr 1 -> a_rvalid 2 cycles after read acceptance, a_rdata=A5A5A5A5.
REQ-026 W-W: both write addr 1 (A=A5A5A5A5, B=5A5A5A5A), prio=0 -> A accepted, b_ready=0 that cycle, B accepted next cycle; later read returns 5A5A5A5A; conflict_cnt=1, prio=1.
REQ-027 R-W: A reads addr 3, B writes 12345678 to addr 3 in the same cycle -> b_ready=1, a_ready=0; A accepted next cycle; a_rdata=12345678.
REQ-028 Throughput: A reads addrs 0..7 on consecutive cycles -> 8 consecutive a_rvalid pulses with data in order.
REQ-029 Saturation: force 70000 W-W conflicts -> conflict_cnt=FFFF, prio alternates each conflict, and neither client waits more than 1 cycle.
